// File: rtl/ascon_perm_ctrl.sv
// Ascon permutation sequencer: takes a 320-bit state over valid/ready, applies
// p12 or p8 at UNROLL rounds per clock, and returns the result over valid/ready.
module ascon_perm_ctrl #(
  parameter int UNROLL = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_mode,
  input  logic [319:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [319:0] out_state,
  output logic         busy,
  output logic [3:0]   round_idx
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [3:0] STEP = 4'(UNROLL);
  localparam logic [3:0] LAST = 4'(16 - UNROLL);

  if (UNROLL != 1 && UNROLL != 2 && UNROLL != 4) begin : g_bad_unroll
    $error("ascon_perm_ctrl: UNROLL must be 1, 2 or 4");
  end

  // Round index r runs 4..F, so the constant is {3 - r, r - 4} in nibbles.
  function automatic logic [7:0] pc(input logic [3:0] idx);
    pc = {4'h3 - idx, idx - 4'h4};
  endfunction

  function automatic logic [63:0] ror(input logic [63:0] x, input int n);
    logic [127:0] d;
    d = {x, x} >> n;
    ror = d[63:0];
  endfunction

  function automatic logic [319:0] ascon_round(input logic [319:0] s, input logic [3:0] idx);
    logic [63:0] x0, x1, x2, x3, x4;
    logic [63:0] t0, t1, t2, t3, t4;
    {x0, x1, x2, x3, x4} = s;
    x2 = x2 ^ {56'h0, pc(idx)};
    x0 = x0 ^ x4;
    x4 = x4 ^ x3;
    x2 = x2 ^ x1;
    t0 = ~x0 & x1;
    t1 = ~x1 & x2;
    t2 = ~x2 & x3;
    t3 = ~x3 & x4;
    t4 = ~x4 & x0;
    x0 = x0 ^ t1;
    x1 = x1 ^ t2;
    x2 = x2 ^ t3;
    x3 = x3 ^ t4;
    x4 = x4 ^ t0;
    x1 = x1 ^ x0;
    x0 = x0 ^ x4;
    x3 = x3 ^ x2;
    x2 = ~x2;
    x0 = x0 ^ ror(x0, 19) ^ ror(x0, 28);
    x1 = x1 ^ ror(x1, 61) ^ ror(x1, 39);
    x2 = x2 ^ ror(x2, 1)  ^ ror(x2, 6);
    x3 = x3 ^ ror(x3, 10) ^ ror(x3, 17);
    x4 = x4 ^ ror(x4, 7)  ^ ror(x4, 41);
    ascon_round = {x0, x1, x2, x3, x4};
  endfunction

  logic [1:0]   fsm_r;
  logic [319:0] st_r;
  logic [3:0]   rnd_r;
  logic         in_ready_r;
  logic         out_valid_r;
  logic [319:0] chain_s [0:UNROLL];

  assign chain_s[0] = st_r;
  for (genvar k = 0; k < UNROLL; k++) begin : g_chain
    assign chain_s[k+1] = ascon_round(chain_s[k], rnd_r + 4'(k));
  end

  // Job sequencing: capture on handshake, iterate the chain, hold result until taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_r       <= IDLE;
      st_r        <= 320'h0;
      rnd_r       <= 4'h0;
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      case (fsm_r)
        IDLE: begin
          if (in_valid && in_ready_r) begin
            st_r       <= in_state;
            rnd_r      <= in_mode ? 4'h8 : 4'h4;
            in_ready_r <= 1'b0;
            fsm_r      <= RUN;
          end else begin
            in_ready_r <= 1'b1;
          end
        end
        RUN: begin
          st_r  <= chain_s[UNROLL];
          rnd_r <= rnd_r + STEP;
          // The last batch leaves rnd_r wrapped to zero.
          if (rnd_r == LAST) begin
            fsm_r       <= DONE;
            out_valid_r <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            fsm_r       <= IDLE;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
          end
        end
        default: begin
          fsm_r       <= IDLE;
          rnd_r       <= 4'h0;
          in_ready_r  <= 1'b0;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_state = st_r;
  assign busy      = (fsm_r != IDLE);
  assign round_idx = (fsm_r == RUN) ? rnd_r : 4'h0;

endmodule

// File: doc/ascon_perm_ctrl.md
# ascon_perm_ctrl

Sequencing controller for the Ascon-AEAD128 permutation. It accepts a 320-bit state and a round-count mode (p12 or p8) over a valid/ready handshake, then iterates the round function over a registered state, UNROLL rounds per cycle. It presents the permuted state on a valid/ready output. It sits between the AEAD mode FSM (initialisation, associated data, plaintext, finalisation) and the round datapath built from the package's constant-addition (`pc`), substitution and linear layers.

## Interface
- `UNROLL`, default 1: rounds per clock. Legal values are 1, 2 and 4; any other value is an elaboration error.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `in_valid`  in  1  input state and mode are valid.
- `in_ready`  out  1  controller can accept a job.
- `in_mode`  in  1  round count: 0 = p12, 1 = p8.
- `in_state`  in  320 (`ascon_state`)  state to permute.
- `out_valid`  out  1  `out_state` holds a finished permutation.
- `out_ready`  in  1  consumer accepts `out_state`.
- `out_state`  out  320 (`ascon_state`)  permuted state, registered.
- `busy`  out  1  high in RUN or DONE.
- `round_idx`  out  4 (`round`)  index of the first round applied this cycle; 0 outside RUN.

## Operation
- Registered state: `fsm` (IDLE, RUN, DONE), `st_q` (320 bits), `rnd_q` (4 bits), `in_ready`.
- Round indexing: the final round always has index 0xF.
  - p12 runs indices 4..F.
  - p8 runs indices 8..F.
  - `pc` derives the round constant from the index.
- Combinational core: UNROLL chained rounds. Round k of the chain uses index `rnd_q + k` and takes its input from round k-1 (round 0 takes `st_q`).
- IDLE:
  - `in_ready` = 1.
  - When `in_valid & in_ready`: `st_q <= in_state`; `rnd_q <= in_mode ? 4'h8 : 4'h4`; `in_ready <= 0`; go to RUN.
  - `in_mode` and `in_state` are sampled only on the handshake edge.
- RUN:
  - Each edge: `st_q <=` chain output and `rnd_q <= rnd_q + UNROLL` (mod 16).
  - When `rnd_q == 16 - UNROLL`, that edge is the last batch: go to DONE, and `rnd_q` wraps to 0.
  - Inputs are ignored.
- DONE:
  - `out_valid` = 1 and `out_state` = `st_q`; both are held stable until `out_ready`.
  - On `out_valid & out_ready`: go to IDLE and set `in_ready <= 1`.
- `out_state` is driven from `st_q` in every state. It is only meaningful while `out_valid` is high.
- No overlap: a new job is accepted no earlier than the edge after the output handshake.

## Timing
- Reset values (while `rst` is high, and immediately on assertion):
  - `fsm` = IDLE.
  - `st_q` = 0 and `out_state` = 0.
  - `rnd_q` = 0 and `round_idx` = 0.
  - `in_ready` = 0, `out_valid` = 0, `busy` = 0.
- After reset release: `in_ready` rises at the first rising edge following deassertion.
- Latency: if the input handshake occurs at edge E, `out_valid` rises after edge E + N/UNROLL.
  - N = 12 for p12 and 8 for p8.
  - UNROLL=1: 12 and 8 cycles. UNROLL=2: 6 and 4. UNROLL=4: 3 and 2.
- Throughput: one job per N/UNROLL + 2 cycles when `out_ready` is held high (one DONE cycle, one IDLE cycle).
- `round_idx` sequences in RUN:
  - UNROLL=1: p12 gives 4,5,…,F; p8 gives 8,…,F.
  - UNROLL=2: p12 gives 4,6,8,A,C,E.
  - UNROLL=4: p8 gives 8,C.
- Backpressure: `out_ready` low in DONE holds `out_valid`, `out_state`, and `busy` indefinitely. `in_ready` stays 0.
- Simultaneous `out_ready` and `in_valid` in DONE: the output is consumed; the input is not accepted (`in_ready` = 0 that cycle).
- `in_valid` held high in RUN/DONE has no effect.
- Reset mid-RUN or mid-DONE: immediate return to reset values. The partial state is discarded and no `out_valid` is produced for the aborted job.
- All outputs are glitch-free registered values, except `busy` and `round_idx`, which decode only registered state.

## Test plan
- Reset behaviour: assert `rst` asynchronously mid-cycle → all outputs 0 immediately; `in_ready` = 1 one edge after release.
- p12, UNROLL=1, `in_state` = {9043340012005440, 4925669902022042, 5532006940392211, 0011134445600600, 1112223333444555}:
  - `out_valid` rises after edge E+12.
  - `round_idx` steps 4..F.
  - `out_state` equals the golden-model p12 result.
- p8 with UNROLL=1, 2 and 4 on the same `in_state` → latencies 8, 4 and 2 cycles, with identical `out_state` matching golden p8.
- Backpressure: hold `out_ready` = 0 for 20 cycles → `out_valid`/`out_state` stable and `in_ready` = 0. Then pulse `out_ready` together with `in_valid` → output consumed, input not taken; the input is accepted one edge later.
- Reset mid-operation: assert `rst` at round index 9 of p12 → no `out_valid`. A following p8 job completes correctly, with no leakage of the old state.
- Back-to-back: 50 random jobs (random mode/state, random `out_ready` stalls) → every output matches the golden model, in order, at the specified latency.
